// File: rtl/mult_pkg.sv
// Shared definitions for the multiplier datapath.
//   ACC_W / TERM_W : accumulator and term widths used by the partial-sum stage
//   state_e        : control FSM states of partial_sum_accumulator
package mult_pkg;
    localparam int ACC_W  = 62;
    localparam int TERM_W = 17;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_e;
endpackage

// File: rtl/customAdder62_45.sv
// Combinational unsigned adder: 62-bit A plus zero-extended 17-bit B.
//   a_i   [61:0] : accumulator operand
//   b_i   [16:0] : term operand (unsigned)
//   sum_o [62:0] : full sum, bit 62 is the carry out
module customAdder62_45
    import mult_pkg::*;
(
    input  logic [ACC_W-1:0]  a_i,
    input  logic [TERM_W-1:0] b_i,
    output logic [ACC_W:0]    sum_o
);
    assign sum_o = (ACC_W+1)'(a_i) + (ACC_W+1)'(b_i);
endmodule

// File: rtl/partial_sum_accumulator.sv
// Loads a 62-bit base value, adds NUM_TERMS unsigned 17-bit terms (one per
// handshake) and presents {sticky overflow, accumulator} on a valid/ready port.
//   clk, rst              : clock, synchronous active-high reset
//   start, init_value     : begin accumulation from init_value (IDLE only)
//   term_valid/ready/data : term input handshake (ready only in ACCUM)
//   res_valid/ready       : result handshake (valid only in DONE)
//   result [62:0]         : {ovf, acc}; held until the next start
//   busy                  : high in ACCUM and DONE
module partial_sum_accumulator
    import mult_pkg::*;
#(
    parameter int NUM_TERMS = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ACC_W-1:0]  init_value,
    input  logic              term_valid,
    output logic              term_ready,
    input  logic [TERM_W-1:0] term_data,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [ACC_W:0]    result,
    output logic              busy
);
    localparam int CNT_W = $clog2(NUM_TERMS + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_TERMS - 1);

    state_e             state_q;
    logic [ACC_W-1:0]   acc_q;
    logic               ovf_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [ACC_W:0]     sum;
    logic               term_acc;

    customAdder62_45 u_adder (
        .a_i   (acc_q),
        .b_i   (term_data),
        .sum_o (sum)
    );

    assign term_acc = (state_q == ACCUM) && term_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        acc_q   <= init_value;
                        ovf_q   <= 1'b0;
                        cnt_q   <= '0;
                        state_q <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (term_acc) begin
                        acc_q <= sum[ACC_W-1:0];
                        // Carry out is sticky for the whole accumulation.
                        ovf_q <= ovf_q | sum[ACC_W];
                        cnt_q <= cnt_q + CNT_W'(1);
                        if (cnt_q == LAST_CNT) state_q <= DONE;
                    end
                end
                DONE: begin
                    // start is deliberately not looked at here.
                    if (res_ready) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Outputs decode straight from registered state: no input-to-output path.
    assign term_ready = (state_q == ACCUM);
    assign res_valid  = (state_q == DONE);
    assign busy       = (state_q != IDLE);
    assign result     = {ovf_q, acc_q};
endmodule

// File: tb/tb_partial_sum_accumulator.sv
module tb_partial_sum_accumulator;
    logic        clk = 1'b0;
    logic        rst;

    // DUT A: NUM_TERMS = 4
    logic        a_start, a_term_valid, a_term_ready, a_res_valid, a_res_ready, a_busy;
    logic [61:0] a_init;
    logic [16:0] a_term_data;
    logic [62:0] a_result;

    // DUT B: NUM_TERMS = 1
    logic        b_start, b_term_valid, b_term_ready, b_res_valid, b_res_ready, b_busy;
    logic [61:0] b_init;
    logic [16:0] b_term_data;
    logic [62:0] b_result;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    partial_sum_accumulator #(.NUM_TERMS(4)) dut_a (
        .clk(clk), .rst(rst), .start(a_start), .init_value(a_init),
        .term_valid(a_term_valid), .term_ready(a_term_ready), .term_data(a_term_data),
        .res_valid(a_res_valid), .res_ready(a_res_ready), .result(a_result), .busy(a_busy)
    );

    partial_sum_accumulator #(.NUM_TERMS(1)) dut_b (
        .clk(clk), .rst(rst), .start(b_start), .init_value(b_init),
        .term_valid(b_term_valid), .term_ready(b_term_ready), .term_data(b_term_data),
        .res_valid(b_res_valid), .res_ready(b_res_ready), .result(b_result), .busy(b_busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic feed_a(input logic v, input logic [16:0] d);
        a_term_valid = v;
        a_term_data  = d;
        tick();
    endtask

    initial begin
        rst = 1'b1;
        a_start = 0; a_init = '0; a_term_valid = 0; a_term_data = '0; a_res_ready = 0;
        b_start = 0; b_init = '0; b_term_valid = 0; b_term_data = '0; b_res_ready = 0;
        tick(); tick();
        rst = 1'b0;

        // Reset state
        chk("rst_term_ready", 64'(a_term_ready), 64'd0);
        chk("rst_res_valid",  64'(a_res_valid),  64'd0);
        chk("rst_busy",       64'(a_busy),       64'd0);
        chk("rst_result",     64'(a_result),     64'd0);

        // term_valid in IDLE is ignored
        feed_a(1'b1, 17'd55);
        chk("idle_term_ready", 64'(a_term_ready), 64'd0);
        chk("idle_result",     64'(a_result),     64'd0);
        a_term_valid = 0;

        // Basic sum: 100 + 1 + 2 + 3 + 4
        a_start = 1; a_init = 62'd100;
        tick();                           // cycle 0 edge
        a_start = 0;
        chk("basic_term_ready_c1", 64'(a_term_ready), 64'd1);
        chk("basic_busy_c1",       64'(a_busy),       64'd1);
        chk("basic_loaded",        64'(a_result),     64'd100);
        feed_a(1, 17'd1);
        feed_a(1, 17'd2);
        feed_a(1, 17'd3);
        chk("basic_not_done_c4",   64'(a_res_valid),  64'd0);
        feed_a(1, 17'd4);
        a_term_valid = 0;
        chk("basic_res_valid_c5",  64'(a_res_valid),  64'd1);
        chk("basic_result",        64'(a_result),     64'd110);
        chk("basic_term_ready_c5", 64'(a_term_ready), 64'd0);
        a_res_ready = 1;
        tick();
        a_res_ready = 0;
        chk("basic_idle_res_valid", 64'(a_res_valid), 64'd0);
        chk("basic_idle_busy",      64'(a_busy),      64'd0);
        chk("basic_result_held",    64'(a_result),    64'd110);

        // Overflow: (2^62-1) + 1 wraps to 0 with sticky carry
        a_start = 1; a_init = {62{1'b1}};
        tick();
        a_start = 0;
        feed_a(1, 17'd1);
        chk("ovf_acc_after_wrap", 64'(a_result), 64'h4000_0000_0000_0000);
        feed_a(1, 17'd0);
        feed_a(1, 17'd0);
        feed_a(1, 17'd0);
        a_term_valid = 0;
        chk("ovf_res_valid", 64'(a_res_valid), 64'd1);
        chk("ovf_result",    64'(a_result),    64'h4000_0000_0000_0000);
        a_res_ready = 1;
        tick();
        a_res_ready = 0;

        // Next accumulation clears overflow
        a_start = 1; a_init = 62'd5;
        tick();
        a_start = 0;
        chk("ovf_cleared_on_start", 64'(a_result), 64'd5);
        feed_a(1, 17'd0);
        feed_a(1, 17'd0);
        feed_a(1, 17'd0);
        feed_a(1, 17'd0);
        a_term_valid = 0;
        chk("ovf2_res_valid", 64'(a_res_valid), 64'd1);
        chk("ovf2_result",    64'(a_result),    64'd5);
        a_res_ready = 1;
        tick();
        a_res_ready = 0;

        // Input stalls: 0x1FFFF on cycles 1,3,5,7, bubbles in between
        a_start = 1; a_init = 62'd0;
        tick();
        a_start = 0;
        feed_a(1, 17'h1FFFF);             // c1
        chk("stall_sum1", 64'(a_result), 64'h1FFFF);
        feed_a(0, 17'h1FFFF);             // c2 bubble: data present but not valid
        chk("stall_hold", 64'(a_result), 64'h1FFFF);
        feed_a(1, 17'h1FFFF);             // c3
        feed_a(0, 17'h0);                 // c4
        feed_a(1, 17'h1FFFF);             // c5
        feed_a(0, 17'h0);                 // c6
        chk("stall_not_done_c7", 64'(a_res_valid), 64'd0);
        chk("stall_still_ready", 64'(a_term_ready), 64'd1);
        feed_a(1, 17'h1FFFF);             // c7
        a_term_valid = 0;
        chk("stall_res_valid_c8", 64'(a_res_valid), 64'd1);
        chk("stall_result",       64'(a_result),    64'h7FFFC);

        // Backpressure for 5 cycles with a start pulse that must be ignored
        for (int i = 0; i < 5; i++) begin
            a_start = (i == 2);
            a_init  = 62'd999;
            tick();
            chk("bp_res_valid", 64'(a_res_valid), 64'd1);
            chk("bp_result",    64'(a_result),    64'h7FFFC);
        end
        // start together with res_ready: only DONE -> IDLE
        a_start = 1; a_res_ready = 1;
        tick();
        a_start = 0; a_res_ready = 0;
        chk("bp_release_res_valid", 64'(a_res_valid), 64'd0);
        chk("bp_release_busy",      64'(a_busy),       64'd0);
        chk("bp_release_result",    64'(a_result),     64'h7FFFC);
        tick();
        chk("bp_start_not_captured", 64'(a_busy), 64'd0);

        // Reset mid-ACCUM after 3 terms
        a_start = 1; a_init = 62'd50;
        tick();
        a_start = 0;
        feed_a(1, 17'd1);
        feed_a(1, 17'd2);
        feed_a(1, 17'd3);
        chk("mid_partial", 64'(a_result), 64'd56);
        rst = 1;
        a_term_valid = 1; a_term_data = 17'd4;
        tick();
        chk("mid_rst_result",     64'(a_result),     64'd0);
        chk("mid_rst_term_ready", 64'(a_term_ready), 64'd0);
        tick();
        rst = 0;
        a_term_valid = 0;
        tick();
        chk("post_rst_res_valid",  64'(a_res_valid),  64'd0);
        chk("post_rst_term_ready", 64'(a_term_ready), 64'd0);
        chk("post_rst_result",     64'(a_result),     64'd0);
        chk("post_rst_busy",       64'(a_busy),       64'd0);

        // NUM_TERMS = 1: 7 + 9
        b_start = 1; b_init = 62'd7;
        tick();
        b_start = 0;
        chk("n1_not_done_c1",  64'(b_res_valid),  64'd0);
        chk("n1_term_ready",   64'(b_term_ready), 64'd1);
        b_term_valid = 1; b_term_data = 17'd9;
        tick();
        b_term_valid = 0;
        chk("n1_res_valid_c2", 64'(b_res_valid), 64'd1);
        chk("n1_result",       64'(b_result),    64'd16);
        b_res_ready = 1;
        tick();
        b_res_ready = 0;
        chk("n1_idle",         64'(b_res_valid), 64'd0);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

    // Hard stop so the run cannot hang.
    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
